// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, immediate formats, decode control bundle and immediate helper.
package riscv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  // 32-bit sign-extended immediate; callers widen to XLEN with a signed cast.
  function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_fmt_t fmt);
    logic [31:0] v;
    v = '0;
    case (fmt)
      IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   v = {ins[31:12], 12'b0};
      IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/register_file.sv
// 2R1W integer register file, x0 hardwired to zero, same-cycle write bypassed onto both reads.
module register_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_wr_en,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr;
  logic            w_rs1_ok;
  logic            w_rs2_ok;

  assign w_wr     = i_wr_en && (i_wr_addr != 5'd0) && (int'(i_wr_addr) < NREGS);
  assign w_rs1_ok = (i_rs1_addr != 5'd0) && (int'(i_rs1_addr) < NREGS);
  assign w_rs2_ok = (i_rs2_addr != 5'd0) && (int'(i_rs2_addr) < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Write-before-read: a write landing this edge is visible to this cycle's decode.
  assign o_rs1_data = !w_rs1_ok                          ? '0        :
                      (w_wr && i_wr_addr == i_rs1_addr)  ? i_wr_data :
                                                           r_regs[i_rs1_addr];
  assign o_rs2_data = !w_rs2_ok                          ? '0        :
                      (w_wr && i_wr_addr == i_rs2_addr)  ? i_wr_data :
                                                           r_regs[i_rs2_addr];

endmodule

// File: rtl/instruction_decode.sv
// RV64I decode stage: register read, immediate generation, control decode into ID/EX registers.
module instruction_decode
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm;
  imm_fmt_t        w_fmt;
  ctrl_t           w_ctrl;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  ctrl_t           r_ctrl;

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wr_en    (wb_en),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data)
  );

  always_comb begin
    w_ctrl = '0;
    w_fmt  = IMM_NONE;
    if (instruction[1:0] != 2'b11) begin
      w_ctrl.illegal = 1'b1;
    end else begin
      case (w_opcode)
        OP: w_ctrl.reg_write = 1'b1;
        OP_IMM: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_I;
        end
        LOAD: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_I;
        end
        JALR: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.jump      = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_I;
        end
        STORE: begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_S;
        end
        BRANCH: begin
          w_ctrl.branch  = 1'b1;
          w_ctrl.alu_src = 1'b1;
          w_fmt          = IMM_B;
        end
        LUI, AUIPC: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_U;
        end
        JAL: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.jump      = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_fmt            = IMM_J;
        end
        default: w_ctrl.illegal = 1'b1;
      endcase
    end
    // Writes to x0 are architecturally dropped; never advertise them downstream.
    if (w_rd == 5'd0) w_ctrl.reg_write = 1'b0;
  end

  assign w_imm = XLEN'($signed(imm32(instruction, w_fmt)));

  // Flush outranks stall; a held stage keeps every field, including data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_ctrl     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
    end else if (!stall) begin
      r_valid    <= valid_in;
      r_ctrl     <= valid_in ? w_ctrl : '0;
      r_pc       <= pc_in;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rd       <= w_rd;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_funct3   <= instruction[14:12];
      r_funct7b5 <= instruction[30];
    end
  end

  assign valid_out = r_valid;
  assign pc_out    = r_pc;
  assign rs1_data  = r_rs1_data;
  assign rs2_data  = r_rs2_data;
  assign imm       = r_imm;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign funct3    = r_funct3;
  assign funct7b5  = r_funct7b5;
  assign reg_write = r_ctrl.reg_write;
  assign mem_read  = r_ctrl.mem_read;
  assign mem_write = r_ctrl.mem_write;
  assign branch    = r_ctrl.branch;
  assign jump      = r_ctrl.jump;
  assign alu_src   = r_ctrl.alu_src;
  assign illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed and randomized checks of instruction_decode against an arithmetic reference model.
module tb_instruction_decode;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic            flush;
  logic            valid_in;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_in;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            valid_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jump;
  logic            alu_src;
  logic            illegal;

  always #5 clk = ~clk;

  instruction_decode #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .valid_in    (valid_in),
    .instruction (instruction),
    .pc_in       (pc_in),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .valid_out   (valid_out),
    .pc_out      (pc_out),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .jump        (jump),
    .alu_src     (alu_src),
    .illegal     (illegal)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: architectural registers and the expected ID/EX contents.
  logic [63:0] m_regs [32];
  logic        m_valid;
  logic [6:0]  m_ctrl;   // {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
  logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [2:0]  m_f3;
  logic        m_f7;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    return 64'($signed(v << (64 - bits)) >>> (64 - bits));
  endfunction

  task automatic ref_decode(input logic [31:0] ins, output logic [6:0] c, output logic [63:0] im);
    logic [63:0] x;
    x  = 64'(ins);
    c  = 7'b0;
    im = 64'd0;
    if (ins[1:0] != 2'b11) c = 7'b0000001;
    else begin
      case (ins[6:0])
        7'h33: c = 7'b1000000;
        7'h13: begin c = 7'b1000010; im = sext(x >> 20, 12); end
        7'h03: begin c = 7'b1100010; im = sext(x >> 20, 12); end
        7'h67: begin c = 7'b1000110; im = sext(x >> 20, 12); end
        7'h23: begin c = 7'b0010010; im = sext(((x >> 25) << 5) | ((x >> 7) & 64'd31), 12); end
        7'h63: begin
          c  = 7'b0001010;
          im = sext((((x >> 31) & 64'd1) << 12) | (((x >> 7) & 64'd1) << 11) |
                    (((x >> 25) & 64'd63) << 5) | (((x >> 8) & 64'd15) << 1), 13);
        end
        7'h37, 7'h17: begin c = 7'b1000010; im = sext(x & 64'hFFFF_F000, 32); end
        7'h6F: begin
          c  = 7'b1000110;
          im = sext((((x >> 31) & 64'd1) << 20) | (((x >> 12) & 64'd255) << 12) |
                    (((x >> 20) & 64'd1) << 11) | (((x >> 21) & 64'd1023) << 1), 21);
        end
        default: c = 7'b0000001;
      endcase
    end
    if (ins[11:7] == 5'd0) c[6] = 1'b0;
  endtask

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_valid = 1'b0; m_ctrl = 7'd0; m_pc = 64'd0; m_rs1d = 64'd0; m_rs2d = 64'd0;
    m_imm = 64'd0; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_f3 = 3'd0; m_f7 = 1'b0;
  endtask

  task automatic model_edge();
    logic [6:0]  c;
    logic [63:0] im;
    if (flush) begin
      m_valid = 1'b0;
      m_ctrl  = 7'd0;
      m_rd    = 5'd0;
    end else if (!stall) begin
      ref_decode(instruction, c, im);
      m_valid = valid_in;
      m_ctrl  = valid_in ? c : 7'd0;
      m_pc    = pc_in;
      m_rs1d  = ref_read(instruction[19:15]);
      m_rs2d  = ref_read(instruction[24:20]);
      m_imm   = im;
      m_rd    = instruction[11:7];
      m_rs1   = instruction[19:15];
      m_rs2   = instruction[24:20];
      m_f3    = instruction[14:12];
      m_f7    = instruction[30];
    end
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal};
  endfunction

  task automatic check_all();
    check("valid_out", 64'(valid_out), 64'(m_valid));
    check("ctrl", 64'(dut_ctrl()), 64'(m_ctrl));
    if (m_valid) begin
      check("pc_out", pc_out, m_pc);
      check("rs1_data", rs1_data, m_rs1d);
      check("rs2_data", rs2_data, m_rs2d);
      check("rd", 64'(rd), 64'(m_rd));
      check("rs1", 64'(rs1), 64'(m_rs1));
      check("rs2", 64'(rs2), 64'(m_rs2));
      check("funct3", 64'(funct3), 64'(m_f3));
      check("funct7b5", 64'(funct7b5), 64'(m_f7));
      if (!m_ctrl[0]) check("imm", imm, m_imm);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_ctrl"}, 64'(dut_ctrl()), 64'd0);
    check({tag, "_pc"}, pc_out, 64'd0);
    check({tag, "_rs1d"}, rs1_data, 64'd0);
    check({tag, "_rs2d"}, rs2_data, 64'd0);
    check({tag, "_imm"}, imm, 64'd0);
    check({tag, "_fields"}, 64'({rd, rs1, rs2, funct3, funct7b5}), 64'd0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic v);
    instruction = ins;
    pc_in       = pc;
    valid_in    = v;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [63:0] d);
    wb_en   = en;
    wb_rd   = a;
    wb_data = d;
  endtask

  localparam logic [31:0] ADDI_X6 = 32'h0050_0313;
  localparam logic [31:0] ADD_X8  = 32'h0073_0433;
  localparam logic [31:0] BEQ_M4  = 32'hFE00_0EE3;
  localparam logic [31:0] ADD_X10 = 32'h0004_8533;  // add x10,x9,x0

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'd0, 64'd0, 1'b0);
    wb(1'b0, 5'd0, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    #10 rst_n = 1'b1;

    // addi x6,x0,5
    drive(ADDI_X6, 64'h1000, 1'b1);
    tick();
    check("addi_rd", 64'(rd), 64'd6);
    check("addi_imm", imm, 64'd5);
    check("addi_rw_as_v", 64'({reg_write, alu_src, valid_out}), 64'b111);

    // fill x6/x7 through write-back, then read them
    drive(ADD_X8, 64'h1004, 1'b0);
    wb(1'b1, 5'd6, 64'd5);
    tick();
    wb(1'b1, 5'd7, 64'd10);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    drive(ADD_X8, 64'h1008, 1'b1);
    tick();
    check("add_rs1d", rs1_data, 64'd5);
    check("add_rs2d", rs2_data, 64'd10);
    check("add_rd", 64'(rd), 64'd8);
    check("add_alu_src", 64'(alu_src), 64'd0);

    // same-cycle bypass, then a write to x0 that must not stick
    wb(1'b1, 5'd6, 64'h99);
    tick();
    check("bypass_rs1d", rs1_data, 64'h99);
    wb(1'b1, 5'd0, 64'd7);
    drive(ADDI_X6, 64'h100C, 1'b1);
    tick();
    check("x0_read", rs1_data, 64'd0);
    wb(1'b0, 5'd0, 64'd0);

    drive(BEQ_M4, 64'h1010, 1'b1);
    tick();
    check("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_br_rw", 64'({branch, reg_write}), 64'b10);

    // stall holds, stall+flush squashes, write-back during stall lands
    drive(ADDI_X6, 64'h2000, 1'b1);
    tick();
    stall = 1'b1;
    drive(BEQ_M4, 64'h3000, 1'b1);
    wb(1'b1, 5'd9, 64'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_out, 64'h2000);
      check("stall_imm", imm, 64'd5);
    end
    wb(1'b0, 5'd0, 64'd0);
    flush = 1'b1;
    tick();
    check("flush_valid_ctrl", 64'({valid_out, dut_ctrl()}), 64'd0);
    check("flush_rd", 64'(rd), 64'd0);
    stall = 1'b0; flush = 1'b0;
    drive(ADD_X10, 64'h2004, 1'b1);
    tick();
    check("stall_wb_landed", rs1_data, 64'h55);

    // asynchronous reset in the middle of a stream
    drive(ADDI_X6, 64'h4000, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("midreset");
    #2 rst_n = 1'b1;
    check("post_release_valid", 64'(valid_out), 64'd0);
    drive(ADD_X8, 64'h4004, 1'b1);
    tick();
    check("regs_cleared", 64'({rs1_data, rs2_data} != 128'd0), 64'd0);

    drive(32'h0000_007F, 64'h4008, 1'b1);
    tick();
    check("illegal_ctrl", 64'(dut_ctrl()), 64'b0000001);

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if ($urandom_range(7) == 0) instruction = r;
      else instruction = {r[31:7], ops[$urandom_range(8)]};
      pc_in    = {$urandom(), $urandom()};
      valid_in = ($urandom_range(4) != 0);
      stall    = ($urandom_range(6) == 0);
      flush    = ($urandom_range(11) == 0);
      wb_en    = $urandom_range(1) == 1;
      r        = $urandom();
      wb_rd    = r[4:0];
      wb_data  = {$urandom(), $urandom()};
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
